// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencer: state codes,
// default sizes and the per-stage control bundle.
package pipe_pkg;

    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_MC  = 2'd1;
    localparam logic [1:0] S_FRZ = 2'd2;

    localparam int CNT_W_DEF         = 16;
    localparam int MC_MAX_CYCLES_DEF = 64;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_bubble;
        logic pc_sel_correct;
    } ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: turns hazard, memory-wait and multi-cycle EX
// handshakes into stage enables, bubbles, flushes and PC select.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEF,
    parameter int MC_MAX_CYCLES = MC_MAX_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stallReq,
    input  logic             flushReq,
    input  logic             cpcReq,
    input  logic             mcStart,
    input  logic             mcDone,
    input  logic             imemReady,
    input  logic             dmemReady,
    output logic             pcEn,
    output logic             ifIdEn,
    output logic             idExEn,
    output logic             exMemEn,
    output logic             memWbEn,
    output logic             ifIdFlush,
    output logic             idExBubble,
    output logic             exMemBubble,
    output logic             pcSelCorrect,
    output logic             mcTimeout,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
);

    localparam int MC_W = (MC_MAX_CYCLES > 2) ? $clog2(MC_MAX_CYCLES) : 1;
    localparam logic [MC_W-1:0] MC_LAST = MC_W'(MC_MAX_CYCLES - 1);

    logic [1:0]      state;
    logic [1:0]      saved;
    logic [1:0]      eff;
    logic            flush_pend;
    logic            cpc_pend;
    logic            timeout_q;
    logic [MC_W-1:0] mc_count;
    logic            frz;
    logic            mc_stall;
    logic            flush_apply;
    ctrl_t           ctrl;

    // A frozen cycle resumes with the decode of the state it interrupted
    assign eff         = (state == S_FRZ) ? saved : state;
    assign frz         = !dmemReady;
    assign mc_stall    = !frz && (eff == S_MC) && !mcDone;
    assign flush_apply = !frz && !mc_stall && (flushReq || flush_pend);

    always_comb begin
        ctrl = '0;
        if (rst_n) begin
            priority case (1'b1)
                frz: begin
                    ctrl = '0;
                end
                mc_stall: begin
                    ctrl.ex_mem_en     = 1'b1;
                    ctrl.mem_wb_en     = 1'b1;
                    ctrl.ex_mem_bubble = 1'b1;
                end
                flush_apply: begin
                    ctrl.pc_en          = 1'b1;
                    ctrl.if_id_en       = 1'b1;
                    ctrl.id_ex_en       = 1'b1;
                    ctrl.ex_mem_en      = 1'b1;
                    ctrl.mem_wb_en      = 1'b1;
                    ctrl.if_id_flush    = 1'b1;
                    ctrl.pc_sel_correct = cpcReq || cpc_pend;
                end
                stallReq: begin
                    ctrl.id_ex_en     = 1'b1;
                    ctrl.ex_mem_en    = 1'b1;
                    ctrl.mem_wb_en    = 1'b1;
                    ctrl.id_ex_bubble = 1'b1;
                end
                !imemReady: begin
                    ctrl.if_id_en    = 1'b1;
                    ctrl.id_ex_en    = 1'b1;
                    ctrl.ex_mem_en   = 1'b1;
                    ctrl.mem_wb_en   = 1'b1;
                    ctrl.if_id_flush = 1'b1;
                end
                default: begin
                    ctrl.pc_en     = 1'b1;
                    ctrl.if_id_en  = 1'b1;
                    ctrl.id_ex_en  = 1'b1;
                    ctrl.ex_mem_en = 1'b1;
                    ctrl.mem_wb_en = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RUN;
            saved     <= S_RUN;
            mc_count  <= '0;
            timeout_q <= 1'b0;
        end else if (frz) begin
            if (state != S_FRZ) begin
                saved <= state;
            end
            state <= S_FRZ;
        end else if (eff == S_MC) begin
            if (mcDone) begin
                state <= S_RUN;
            end else if (mc_count == MC_LAST) begin
                state     <= S_RUN;
                timeout_q <= 1'b1;
            end else begin
                state    <= S_MC;
                mc_count <= mc_count + 1'b1;
            end
        end else if (mcStart && !mcDone) begin
            state    <= S_MC;
            mc_count <= '0;
        end else begin
            state <= S_RUN;
        end
    end

    // Requests that arrive while blocked collapse into one pending flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pend <= 1'b0;
            cpc_pend   <= 1'b0;
        end else begin
            if ((frz || mc_stall) && flushReq) begin
                flush_pend <= 1'b1;
            end else if (flush_apply) begin
                flush_pend <= 1'b0;
            end
            if ((frz || mc_stall) && cpcReq) begin
                cpc_pend <= 1'b1;
            end else if (flush_apply) begin
                cpc_pend <= 1'b0;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!ctrl.pc_en),
        .count (stallCnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_apply),
        .count (flushCnt)
    );

    assign pcEn         = ctrl.pc_en;
    assign ifIdEn       = ctrl.if_id_en;
    assign idExEn       = ctrl.id_ex_en;
    assign exMemEn      = ctrl.ex_mem_en;
    assign memWbEn      = ctrl.mem_wb_en;
    assign ifIdFlush    = ctrl.if_id_flush;
    assign idExBubble   = ctrl.id_ex_bubble;
    assign exMemBubble  = ctrl.ex_mem_bubble;
    assign pcSelCorrect = ctrl.pc_sel_correct;
    assign mcTimeout    = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed per-cycle vectors with
// hand-computed expected controls and counter values.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stallReq, flushReq, cpcReq, mcStart, mcDone;
    logic        imemReady, dmemReady;
    logic        pcEn, ifIdEn, idExEn, exMemEn, memWbEn;
    logic        ifIdFlush, idExBubble, exMemBubble, pcSelCorrect, mcTimeout;
    logic [15:0] stallCnt, flushCnt;
    logic [9:0]  act;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(16), .MC_MAX_CYCLES(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stallReq     (stallReq),
        .flushReq     (flushReq),
        .cpcReq       (cpcReq),
        .mcStart      (mcStart),
        .mcDone       (mcDone),
        .imemReady    (imemReady),
        .dmemReady    (dmemReady),
        .pcEn         (pcEn),
        .ifIdEn       (ifIdEn),
        .idExEn       (idExEn),
        .exMemEn      (exMemEn),
        .memWbEn      (memWbEn),
        .ifIdFlush    (ifIdFlush),
        .idExBubble   (idExBubble),
        .exMemBubble  (exMemBubble),
        .pcSelCorrect (pcSelCorrect),
        .mcTimeout    (mcTimeout),
        .stallCnt     (stallCnt),
        .flushCnt     (flushCnt)
    );

    // inputs: {rst_n, stall, flush, cpc, mcStart, mcDone, imem, dmem}
    localparam logic [7:0] RST     = 8'b0000_0011;
    localparam logic [7:0] IDLE    = 8'b1000_0011;
    localparam logic [7:0] STL     = 8'b1100_0011;
    localparam logic [7:0] MCS     = 8'b1000_1011;
    localparam logic [7:0] MCD     = 8'b1000_0111;
    localparam logic [7:0] DMW     = 8'b1000_0010;
    localparam logic [7:0] DMW_FC  = 8'b1011_0010;
    localparam logic [7:0] FLS_STL = 8'b1110_0011;
    localparam logic [7:0] IMW     = 8'b1000_0001;

    // expected: {pc,ifId,idEx,exMem,memWb, ifIdFl,idExBub,exMemBub, pcSel, timeout}
    localparam logic [9:0] E_ZERO = 10'b00000_000_00;
    localparam logic [9:0] E_ALL  = 10'b11111_000_00;
    localparam logic [9:0] E_STL  = 10'b00111_010_00;
    localparam logic [9:0] E_MC   = 10'b00011_001_00;
    localparam logic [9:0] E_FL   = 10'b11111_100_00;
    localparam logic [9:0] E_FLC  = 10'b11111_100_10;
    localparam logic [9:0] E_IMW  = 10'b01111_100_00;
    localparam logic [9:0] E_TO   = 10'b00000_000_01;

    typedef struct {
        string      name;
        logic [9:0] ctrl;
        int         s;
        int         f;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic cyc(input string name, input logic [7:0] in,
                       input logic [9:0] e, input int s, input int f);
        {rst_n, stallReq, flushReq, cpcReq, mcStart, mcDone,
         imemReady, dmemReady} = in;
        q.push_back('{name, e, s, f});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            act = {pcEn, ifIdEn, idExEn, exMemEn, memWbEn,
                   ifIdFlush, idExBubble, exMemBubble, pcSelCorrect, mcTimeout};
            checks++;
            if (act !== x.ctrl) begin
                errors++;
                $display("FAIL %s ctrl: got %b want %b", x.name, act, x.ctrl);
            end
            if (x.s >= 0) begin
                checks++;
                if (stallCnt !== 16'(x.s)) begin
                    errors++;
                    $display("FAIL %s stallCnt: got %0d want %0d",
                             x.name, stallCnt, x.s);
                end
            end
            if (x.f >= 0) begin
                checks++;
                if (flushCnt !== 16'(x.f)) begin
                    errors++;
                    $display("FAIL %s flushCnt: got %0d want %0d",
                             x.name, flushCnt, x.f);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        {rst_n, stallReq, flushReq, cpcReq, mcStart, mcDone,
         imemReady, dmemReady} = RST;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) cyc("reset", RST, E_ZERO, 0, 0);
        cyc("release", IDLE, E_ALL, 0, 0);
        cyc("run", IDLE, E_ALL, 0, 0);

        cyc("stall", STL, E_STL, 0, 0);
        cyc("after_stall", IDLE, E_ALL, 1, 0);

        cyc("mc_start", MCS, E_ALL, 1, 0);
        for (int k = 0; k < 5; k++) cyc("mc_busy", IDLE, E_MC, 1 + k, 0);
        cyc("mc_done", MCD, E_ALL, 6, 0);
        cyc("mc_after", IDLE, E_ALL, 6, 0);

        cyc("freeze1", DMW, E_ZERO, 6, 0);
        cyc("freeze2_flush", DMW_FC, E_ZERO, 7, 0);
        cyc("freeze3_flush", DMW_FC, E_ZERO, 8, 0);
        cyc("freeze4", DMW, E_ZERO, 9, 0);
        cyc("pend_flush", IDLE, E_FLC, 10, 0);
        cyc("after_pend", IDLE, E_ALL, 10, 1);

        cyc("flush_stall", FLS_STL, E_FL, 10, 1);
        cyc("after_fs", IDLE, E_ALL, 10, 2);

        cyc("imem_wait", IMW, E_IMW, 10, 2);
        cyc("after_imem", IDLE, E_ALL, 11, 2);

        cyc("to_start", MCS, E_ALL, 11, 2);
        for (int k = 0; k < 8; k++) cyc("to_busy", IDLE, E_MC, 11 + k, 2);
        cyc("to_resume", IDLE, E_ALL | E_TO, 19, 2);
        cyc("to_sticky", IDLE, E_ALL | E_TO, 19, 2);

        cyc("mc_again", MCS, E_ALL | E_TO, 19, 2);
        cyc("mc_busy2", IDLE, E_MC | E_TO, 19, 2);
        cyc("mid_reset", RST, E_ZERO, 0, 0);
        cyc("post_reset", IDLE, E_ALL, 0, 0);
        cyc("post_reset2", IDLE, E_ALL, 0, 0);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
